// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating bubble counter.
// Latency 1 cycle ID->EX; flush > freeze_in > hazard > load; hazard_stall holds PC and IF/ID.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_in,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [4:0]        id_exec_cmd,
    input  logic [7:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_src2_used,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [4:0]        ex_exec_cmd,
    output logic [7:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_st_val,
    output logic [REG_W-1:0]  ex_dest,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [4:0]        cmd_q, cmd_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] val1_q, val1_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hz;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign hz = id_valid & valid_q & ctrl_q[1] & (dest_q != '0) &
                ((dest_q == id_src1) | (id_src2_used & (dest_q == id_src2)));

    assign hazard_stall = hz & ~flush & ~freeze_in;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        cmd_d   = cmd_q;
        ctrl_d  = ctrl_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        st_d    = st_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        if (flush || (!freeze_in && hz)) begin
            valid_d = 1'b0;
            pc_d    = '0;
            cmd_d   = '0;
            ctrl_d  = '0;
            val1_d  = '0;
            val2_d  = '0;
            st_d    = '0;
            dest_d  = '0;
            if (!flush && cnt_q != '1)
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!freeze_in) begin
            valid_d = id_valid;
            pc_d    = id_pc;
            cmd_d   = id_exec_cmd;
            ctrl_d  = id_ctrl;
            val1_d  = id_val1;
            val2_d  = id_val2;
            st_d    = id_st_val;
            dest_d  = id_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            cmd_q   <= '0;
            ctrl_q  <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            st_q    <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            ctrl_q  <= ctrl_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            st_q    <= st_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_exec_cmd = cmd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_val1     = val1_q;
    assign ex_val2     = val2_q;
    assign ex_st_val   = st_q;
    assign ex_dest     = dest_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed steps with a scoreboard of expected EX state per clock.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, freeze_in, flush, id_valid, id_src2_used;
    logic [DW-1:0] id_pc, id_val1, id_val2, id_st_val;
    logic [4:0]    id_exec_cmd;
    logic [7:0]    id_ctrl;
    logic [RW-1:0] id_dest, id_src1, id_src2;

    logic          ex_valid, hazard_stall, ex_valid_s, hazard_stall_s;
    logic [DW-1:0] ex_pc, ex_val1, ex_val2, ex_st_val;
    logic [DW-1:0] ex_pc_s, ex_val1_s, ex_val2_s, ex_st_val_s;
    logic [4:0]    ex_exec_cmd, ex_exec_cmd_s;
    logic [7:0]    ex_ctrl, ex_ctrl_s;
    logic [RW-1:0] ex_dest, ex_dest_s;
    logic [15:0]   bubble_cnt;
    logic [1:0]    bubble_cnt_s;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_exec_cmd(id_exec_cmd), .id_ctrl(id_ctrl), .id_val1(id_val1),
        .id_val2(id_val2), .id_st_val(id_st_val), .id_dest(id_dest), .id_src1(id_src1),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_exec_cmd(ex_exec_cmd), .ex_ctrl(ex_ctrl), .ex_val1(ex_val1), .ex_val2(ex_val2),
        .ex_st_val(ex_st_val), .ex_dest(ex_dest), .hazard_stall(hazard_stall),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_exec_cmd(id_exec_cmd), .id_ctrl(id_ctrl), .id_val1(id_val1),
        .id_val2(id_val2), .id_st_val(id_st_val), .id_dest(id_dest), .id_src1(id_src1),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .ex_valid(ex_valid_s), .ex_pc(ex_pc_s),
        .ex_exec_cmd(ex_exec_cmd_s), .ex_ctrl(ex_ctrl_s), .ex_val1(ex_val1_s), .ex_val2(ex_val2_s),
        .ex_st_val(ex_st_val_s), .ex_dest(ex_dest_s), .hazard_stall(hazard_stall_s),
        .bubble_cnt(bubble_cnt_s)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] pc, val1, val2, st;
        logic [4:0]    cmd;
        logic [7:0]    ctrl;
        logic [RW-1:0] dest;
        logic [15:0]   cnt;
        logic [1:0]    cnt2;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t zero_state();
        exp_t z;
        z.valid = 1'b0; z.pc = '0; z.val1 = '0; z.val2 = '0; z.st = '0;
        z.cmd = '0; z.ctrl = '0; z.dest = '0; z.cnt = '0; z.cnt2 = '0;
        return z;
    endfunction

    function automatic logic model_hz();
        return id_valid & m.valid & m.ctrl[1] & (m.dest != 0) &
               ((m.dest == id_src1) | (id_src2_used & (m.dest == id_src2)));
    endfunction

    // One clock: check the combinational stall, predict the next EX state, then compare after the edge.
    task automatic step();
        exp_t n, e;
        logic h;
        #2;
        h = model_hz();
        chk("hazard_stall", hazard_stall, h & ~flush & ~freeze_in);
        chk("hazard_stall_sat", hazard_stall_s, h & ~flush & ~freeze_in);
        n = m;
        if (!rst) begin
            n = zero_state();
        end else if (flush) begin
            n = zero_state();
            n.cnt = m.cnt; n.cnt2 = m.cnt2;
        end else if (freeze_in) begin
            n = m;
        end else if (h) begin
            n = zero_state();
            n.cnt  = (m.cnt == 16'hffff) ? m.cnt : m.cnt + 16'd1;
            n.cnt2 = (m.cnt2 == 2'b11) ? m.cnt2 : m.cnt2 + 2'd1;
        end else begin
            n.valid = id_valid; n.pc = id_pc; n.val1 = id_val1; n.val2 = id_val2;
            n.st = id_st_val; n.cmd = id_exec_cmd; n.ctrl = id_ctrl; n.dest = id_dest;
        end
        sb.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("ex_valid", ex_valid, e.valid);
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_exec_cmd", ex_exec_cmd, e.cmd);
            chk("ex_ctrl", ex_ctrl, e.ctrl);
            chk("ex_val1", ex_val1, e.val1);
            chk("ex_val2", ex_val2, e.val2);
            chk("ex_st_val", ex_st_val, e.st);
            chk("ex_dest", ex_dest, e.dest);
            chk("bubble_cnt", bubble_cnt, e.cnt);
            chk("bubble_cnt_sat", bubble_cnt_s, e.cnt2);
            chk("ex_valid_sat", ex_valid_s, e.valid);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] cmd, input logic [7:0] ctrl,
                         input logic [RW-1:0] dest, input logic [RW-1:0] s1,
                         input logic [RW-1:0] s2, input logic s2u,
                         input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        id_valid = v; id_exec_cmd = cmd; id_ctrl = ctrl; id_dest = dest;
        id_src1 = s1; id_src2 = s2; id_src2_used = s2u; id_val1 = v1; id_val2 = v2;
        id_pc = id_pc + 32'd4; id_st_val = v2 ^ 32'h5a5a_0000;
    endtask

    localparam logic [7:0] C_ADDI = 8'h14;
    localparam logic [7:0] C_ADD  = 8'h04;
    localparam logic [7:0] C_LD   = 8'h06;

    initial begin
        m = zero_state();
        rst = 1'b0; freeze_in = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_pc = $urandom; id_exec_cmd = 5'($urandom);
        id_ctrl = 8'($urandom); id_val1 = $urandom; id_val2 = $urandom; id_st_val = $urandom;
        id_dest = 5'($urandom); id_src1 = 5'($urandom); id_src2 = 5'($urandom);
        id_src2_used = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        chk("reset_valid", ex_valid, 0);
        chk("reset_cnt", bubble_cnt, 0);
        rst = 1'b1;

        // normal flow: ADDI r3 = 5 + 7
        drive(1, 5'd0, C_ADDI, 5'd3, 5'd1, 5'd2, 0, 32'd5, 32'd7);
        step();
        chk("addi_ctrl", ex_ctrl, 8'h14);
        chk("addi_val1", ex_val1, 5);
        chk("addi_val2", ex_val2, 7);
        chk("addi_dest", ex_dest, 3);
        chk("addi_valid", ex_valid, 1);

        // load-use on src1: exactly one bubble
        drive(1, 5'd0, C_LD, 5'd4, 5'd1, 5'd0, 0, 32'd100, 32'd8);
        step();
        drive(1, 5'd2, C_ADD, 5'd6, 5'd4, 5'd5, 1, 32'd11, 32'd12);
        #1 chk("lu_stall_now", hazard_stall, 1);
        step();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        step();
        chk("lu_after_dest", ex_dest, 6);
        chk("lu_after_valid", ex_valid, 1);

        // src2 match but src2 unused: no stall
        drive(1, 5'd0, C_LD, 5'd4, 5'd1, 5'd0, 0, 32'd1, 32'd2);
        step();
        drive(1, 5'd2, C_ADD, 5'd7, 5'd9, 5'd4, 0, 32'd3, 32'd4);
        #1 chk("src2_unused_stall", hazard_stall, 0);
        step();
        chk("src2_unused_valid", ex_valid, 1);

        // r0 exemption
        drive(1, 5'd0, C_LD, 5'd0, 5'd1, 5'd0, 0, 32'd1, 32'd2);
        step();
        drive(1, 5'd2, C_ADD, 5'd8, 5'd0, 5'd0, 1, 32'd3, 32'd4);
        #1 chk("r0_stall", hazard_stall, 0);
        step();
        chk("r0_valid", ex_valid, 1);

        // flush wins over freeze
        flush = 1'b1; freeze_in = 1'b1;
        step();
        chk("flush_freeze_valid", ex_valid, 0);
        chk("flush_freeze_val1", ex_val1, 0);
        flush = 1'b0; freeze_in = 1'b0;

        // freeze holds everything even with a hazard present
        drive(1, 5'd0, C_LD, 5'd4, 5'd1, 5'd0, 0, 32'd77, 32'd8);
        step();
        drive(1, 5'd2, C_ADD, 5'd6, 5'd4, 5'd5, 1, 32'd11, 32'd12);
        freeze_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("freeze_val1", ex_val1, 77);
        chk("freeze_cnt", bubble_cnt, 1);
        freeze_in = 1'b0;
        step();
        chk("unfreeze_bubble_cnt", bubble_cnt, 2);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd0, C_LD, 5'd9, 5'd1, 5'd0, 0, 32'(i), 32'd8);
            step();
            drive(1, 5'd2, C_ADD, 5'd10, 5'd2, 5'd9, 1, 32'd1, 32'd1);
            step();
        end
        chk("sat_cnt2", bubble_cnt_s, 3);
        chk("sat_cnt16", bubble_cnt, 7);

        // id_valid=0: payload passes, ex_valid stays low
        drive(0, 5'd3, C_ADD, 5'd12, 5'd1, 5'd2, 1, 32'hdead_beef, 32'd5);
        step();
        chk("invalid_val1", ex_val1, 32'hdead_beef);
        chk("invalid_valid", ex_valid, 0);

        // reset while stalling
        drive(1, 5'd0, C_LD, 5'd4, 5'd1, 5'd0, 0, 32'd1, 32'd2);
        step();
        drive(1, 5'd2, C_ADD, 5'd6, 5'd4, 5'd5, 1, 32'd11, 32'd12);
        #1 chk("pre_reset_stall", hazard_stall, 1);
        rst = 1'b0;
        step();
        chk("mid_reset_stall", hazard_stall, 0);
        chk("mid_reset_cnt", bubble_cnt, 0);
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
